sram_mem_controller: RTL
========================

Name: sram_mem_controller

Overview:
- Responder side of the pipeline data-memory interface: serves the MEM stage's load/store requests from off-chip 16-bit SRAM (DE2-style) in place of the on-chip register array.
- Splits each 32-bit word access into two 16-bit SRAM accesses.
- Holds `ready` low to freeze the pipeline until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM address width.
- WAIT_CYCLES, 1: extra hold cycles per 16-bit half-access, to meet SRAM tAA/tWP; legal range 0..7.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  load request from MEM stage.
- wr_en  in  1  store request from MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store value.
- read_data  out  32  load value; valid from the `ready` cycle of a read until the next read completes.
- ready  out  1  high = no access pending / access done this cycle; low = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address.
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low.

Behaviour:
- One clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE, read_data = 0.
  - SRAM_WE_N = 1, SRAM_OE_N = 1.
  - SRAM_CE_N = 0, SRAM_UB_N = 0, SRAM_LB_N = 0 (chip always selected, both byte lanes enabled).
  - SRAM_DQ = high-Z, SRAM_ADDR = 0.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits; address[1:0] is ignored.
  - Low half is at SRAM_ADDR = {word, 0}; high half is at {word, 1}.
  - Out-of-range addresses wrap modulo the SRAM size; no error is raised.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en or wr_en is high, latch address, write_data and op (write if wr_en, else read), then go to LO.
  - If wr_en and rd_en are both high, the write wins.
- LO:
  - Lasts exactly WAIT_CYCLES+1 cycles, counted by an internal 3-bit counter; then go to HI.
- HI:
  - Same duration as LO; then go to DONE.
- DONE:
  - Lasts 1 cycle; go to IDLE unconditionally. A request still present in that IDLE cycle starts a new access.
- ready is combinational:
  - ready = (state == IDLE && !rd_en && !wr_en) || state == DONE.
  - It drops in the same cycle the request appears.
  - Latency: ready is low for 1 + 2*(WAIT_CYCLES+1) cycles; 5 cycles at default, with ready high in the 6th.
- Write phase (LO/HI):
  - SRAM_ADDR = half address.
  - SRAM_DQ driven with write_data[15:0] in LO, write_data[31:16] in HI.
  - SRAM_WE_N = 0 in every cycle of the phase except the last, where it is 1 so data/address hold past the WE rising edge. With WAIT_CYCLES = 0, WE_N is low for the whole single cycle.
  - SRAM_OE_N = 1.
- Read phase (LO/HI):
  - SRAM_DQ high-Z, SRAM_OE_N = 0, SRAM_WE_N = 1.
  - On the rising edge ending the last cycle of LO, sample SRAM_DQ into read_data[15:0]; likewise HI into read_data[31:16].
- IDLE/DONE: DQ high-Z, WE_N = OE_N = 1.
- Request inputs are ignored outside IDLE; the MEM stage must hold them stable while ready = 0, and the controller uses the latched copies.
- Reset asserted mid-access: immediate return to IDLE, DQ released, WE_N high. The interrupted write may be partial; no recovery is attempted.
- read_data is unchanged by writes.

Decomposition:
- Shared package: state encoding (IDLE, LO, HI, DONE), BASE_ADDR default, SRAM_AW default.
- RTL: single module; the wait counter and DQ tristate stay inline.
- Bench: behavioural `sram_model` (16-bit array, honours WE_N/OE_N) is the natural companion sub-module.

Test Plan:
- Write, then read back: wr_en with address = 1028, write_data = 0xDEADBEEF.
  - sram_model[2] = 0xBEEF and [3] = 0xDEAD; ready low 5 cycles, high in the 6th.
  - Then rd_en at 1028 gives read_data = 0xDEADBEEF in the ready cycle.
- WAIT_CYCLES = 0 and 3: ready low 3 and 9 cycles respectively; data correct in both.
- Simultaneous request: rd_en = wr_en = 1, address = 1032, write_data = 0x12345678.
  - Write performed; read_data keeps its previous value; sram_model[4] = 0x5678.
- Back-to-back: read 1024, then write 1036 presented in the IDLE cycle after DONE.
  - No idle gap beyond that IDLE cycle; both ops correct.
  - DQ never driven while OE_N = 0 (bench contention check).
- Reset mid-access: assert rst_n = 0 during the HI phase of a write.
  - Same cycle: WE_N = 1, DQ = Z, read_data = 0.
  - After release: ready = 1 with no request; next read completes normally.
- Address wrap and alignment: address = 1024 + 4*2^17 + 3 maps to word 0 (SRAM_ADDR 0/1).

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
// rtl/sram_mem_controller_pkg.sv - shared state encoding and defaults for the SRAM data-memory controller
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam int DEFAULT_BASE_ADDR   = 1024;
    localparam int DEFAULT_SRAM_AW     = 18;
    localparam int DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/sram_mem_controller_if.sv
// rtl/sram_mem_controller_if.sv - MEM-stage load/store request bus between pipeline and memory responder
interface sram_mem_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - serves 32-bit pipeline loads/stores as two 16-bit off-chip SRAM accesses
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW     = DEFAULT_SRAM_AW,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_mem_controller_if.slave bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [2:0]  WAIT_CNT = 3'(WAIT_CYCLES);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);

    state_t             state;
    logic [2:0]         cnt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wdata;
    logic [31:0]        read_data_q;
    logic [15:0]        dq_out;
    logic               dq_oe;
    logic [31:0]        offset;
    logic               last;
    logic               unused_addr_bits;

    assign offset           = bus.address - BASE;
    assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign last             = (cnt == WAIT_CNT);

    assign bus.ready     = ((state == IDLE) && !bus.rd_en && !bus.wr_en) || (state == DONE);
    assign bus.read_data = read_data_q;

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Outputs are registered one cycle ahead: each branch sets up what the SRAM sees next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            op_wr       <= 1'b0;
            word        <= '0;
            wdata       <= 32'd0;
            read_data_q <= 32'd0;
            dq_out      <= 16'd0;
            dq_oe       <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_en || bus.wr_en) begin
                        op_wr     <= bus.wr_en;
                        word      <= offset[SRAM_AW:2];
                        wdata     <= bus.write_data;
                        cnt       <= 3'd0;
                        state     <= LO;
                        SRAM_ADDR <= {offset[SRAM_AW:2], 1'b0};
                        SRAM_WE_N <= !bus.wr_en;
                        SRAM_OE_N <= bus.wr_en;
                        dq_oe     <= bus.wr_en;
                        dq_out    <= bus.write_data[15:0];
                    end
                end
                LO, HI: begin
                    if (!last) begin
                        cnt <= cnt + 3'd1;
                        // Raise WE one cycle early so address/data hold past its rising edge.
                        if (op_wr && (cnt + 3'd1 == WAIT_CNT)) begin
                            SRAM_WE_N <= 1'b1;
                        end
                    end else if (state == LO) begin
                        if (!op_wr) begin
                            read_data_q[15:0] <= SRAM_DQ;
                        end
                        cnt       <= 3'd0;
                        state     <= HI;
                        SRAM_ADDR <= {word, 1'b1};
                        SRAM_WE_N <= !op_wr;
                        dq_out    <= wdata[31:16];
                    end else begin
                        if (!op_wr) begin
                            read_data_q[31:16] <= SRAM_DQ;
                        end
                        cnt       <= 3'd0;
                        state     <= DONE;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
